// File: rtl/darkmem_pkg.sv
// rtl/darkmem_pkg.sv - shared types, constants and byte-merge helper for darklatmem
package darkmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: bits 0,2,3,5 are taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/darklatmem_if.sv
// rtl/darklatmem_if.sv - PAB request / MEM completion handshake bundle
interface darklatmem_if;
  logic        PAB_VALID;
  logic        PAB_RD;
  logic        PAB_WR;
  logic [31:0] PAB_ADDR;
  logic [31:0] PAB_DATA;
  logic [3:0]  PAB_BE;
  logic        MEM_READY;
  logic        MEM_VALID;
  logic [31:0] MEM_DATA;
  logic        MEM_ERR;

  modport master (
    output PAB_VALID, PAB_RD, PAB_WR, PAB_ADDR, PAB_DATA, PAB_BE,
    input  MEM_READY, MEM_VALID, MEM_DATA, MEM_ERR
  );

  modport slave (
    input  PAB_VALID, PAB_RD, PAB_WR, PAB_ADDR, PAB_DATA, PAB_BE,
    output MEM_READY, MEM_VALID, MEM_DATA, MEM_ERR
  );
endinterface

// File: rtl/darklfsr16.sv
// rtl/darklfsr16.sv - 16-bit Fibonacci LFSR, advances only when EN is high
module darklfsr16
  import darkmem_pkg::*;
(
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        EN,
  output logic [15:0] Q
);

  logic [15:0] q_q, q_d;
  logic        fb;

  always_comb begin
    fb  = ^(q_q & LFSR_TAPS);
    q_d = EN ? {fb, q_q[15:1]} : q_q;
  end

  always_ff @(posedge XCLK) begin
    if (XRES) q_q <= LFSR_SEED;
    else      q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/darklatmem.sv
// rtl/darklatmem.sv - fake-latency word RAM with IO register, error flag and completion counter
module darklatmem
  import darkmem_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int LATENCY  = 15,
  parameter int LAT_MODE = 0,
  parameter int JITTER_W = 2,
  parameter int NLEDS    = 4
) (
  input  logic             XCLK,
  input  logic             XRES,
  darklatmem_if.slave      bus,
  output logic [NLEDS-1:0] LEDS,
  output logic [31:0]      REQ_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 9;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:2]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic          ready_q, ready_d, valid_q, valid_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d, ioreg_q, ioreg_d, req_cnt_q, req_cnt_d;
  logic [31:0]   ram_q [DEPTH];

  logic          ram_we, lfsr_en, is_io, is_oor, unused_bits;
  logic [15:0]   lfsr_q;
  logic [AW-1:0] idx;
  logic [CW-1:0] load_cnt;

  darklfsr16 u_lfsr (.XCLK(XCLK), .XRES(XRES), .EN(lfsr_en), .Q(lfsr_q));

  assign idx         = addr_q[AW+1:2];
  assign is_io       = addr_q[31];
  assign is_oor      = !addr_q[31] && (addr_q[30:AW+2] != '0);
  assign load_cnt    = (LAT_MODE == 1) ? CW'(LATENCY) + CW'(lfsr_q[JITTER_W-1:0]) : CW'(LATENCY);
  assign unused_bits = ^{bus.PAB_ADDR[1:0], lfsr_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    ioreg_d   = ioreg_q;
    req_cnt_d = req_cnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    lfsr_en   = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.PAB_VALID && (bus.PAB_RD || bus.PAB_WR)) begin
          addr_d  = bus.PAB_ADDR[31:2];
          wdata_d = bus.PAB_DATA;
          be_d    = bus.PAB_BE;
          rd_d    = bus.PAB_RD;
          wr_d    = bus.PAB_WR;
          cnt_d   = load_cnt;
          lfsr_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Read samples the old word; a combined RD+WR returns pre-write data.
          if (rd_q) rdata_d = is_oor ? ERR_DATA : (is_io ? ioreg_q : ram_q[idx]);
          if (wr_q && is_io) ioreg_d = merge_be(ioreg_q, wdata_q, be_q);
          ram_we    = wr_q && !is_io && !is_oor;
          valid_d   = 1'b1;
          err_d     = is_oor;
          req_cnt_d = req_cnt_q + 32'd1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.PAB_VALID) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d = (state_d == IDLE);

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      ioreg_q   <= '0;
      req_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ioreg_q   <= ioreg_d;
      req_cnt_q <= req_cnt_d;
    end
  end

  // RAM has no reset; the XRES gate keeps an aborted request from writing.
  always_ff @(posedge XCLK) begin
    if (!XRES && ram_we) ram_q[idx] <= merge_be(ram_q[idx], wdata_q, be_q);
  end

  assign bus.MEM_READY = ready_q;
  assign bus.MEM_VALID = valid_q;
  assign bus.MEM_DATA  = rdata_q;
  assign bus.MEM_ERR   = err_q;
  assign LEDS          = ioreg_q[NLEDS-1:0];
  assign REQ_CNT       = req_cnt_q;

endmodule

// File: tb/tb_darklatmem.sv
// tb/tb_darklatmem.sv - self-checking bench for darklatmem (fixed and jittered latency)
module tb_darklatmem;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [3:0]  leds0, leds1;
  logic [31:0] cnt0, cnt1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  darklatmem_if i0 ();
  darklatmem_if i1 ();

  darklatmem #(.DEPTH(16), .LATENCY(3), .LAT_MODE(0), .JITTER_W(2), .NLEDS(4)) u_dut0 (
    .XCLK(clk), .XRES(rst0), .bus(i0), .LEDS(leds0), .REQ_CNT(cnt0));

  darklatmem #(.DEPTH(16), .LATENCY(2), .LAT_MODE(1), .JITTER_W(2), .NLEDS(4)) u_dut1 (
    .XCLK(clk), .XRES(rst1), .bus(i1), .LEDS(leds1), .REQ_CNT(cnt1));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_leds;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (sel == 0) begin
      i0.PAB_VALID = v; i0.PAB_RD = rd; i0.PAB_WR = wr;
      i0.PAB_ADDR = a; i0.PAB_DATA = d; i0.PAB_BE = be;
    end else begin
      i1.PAB_VALID = v; i1.PAB_RD = rd; i1.PAB_WR = wr;
      i1.PAB_ADDR = a; i1.PAB_DATA = d; i1.PAB_BE = be;
    end
  endtask

  function automatic logic f_ready(input int sel);
    return (sel == 0) ? i0.MEM_READY : i1.MEM_READY;
  endfunction
  function automatic logic f_valid(input int sel);
    return (sel == 0) ? i0.MEM_VALID : i1.MEM_VALID;
  endfunction
  function automatic logic [31:0] f_data(input int sel);
    return (sel == 0) ? i0.MEM_DATA : i1.MEM_DATA;
  endfunction
  function automatic logic f_err(input int sel);
    return (sel == 0) ? i0.MEM_ERR : i1.MEM_ERR;
  endfunction

  // Caller is positioned #1 after a rising edge; returns likewise.
  task automatic txn(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    while (!f_ready(sel) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("ready_before[%0d]", sel), 32'(f_ready(sel)), 32'd1);
    drive(sel, 1'b1, rd, wr, a, d, be);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1; n++;
      if (f_valid(sel)) break;
    end
    lat   = f_valid(sel) ? n - 1 : -1;
    rdata = f_data(sel);
    err   = f_err(sel);
    @(posedge clk); #1;
    chk($sformatf("valid_pulse[%0d]", sel), 32'(f_valid(sel)), 32'd0);
    chk($sformatf("ready_after[%0d]", sel), 32'(f_ready(sel)), 32'd1);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] bit0;
    bit0 = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h1;
    return (l >> 1) | (bit0 << 15);
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (nw & m);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdata, a, d;
    logic        err, rd, wr, seen;
    logic [3:0]  be;
    int          lat, exp_lat, op, k, idx;
    logic [31:0] mram[16];
    logic [31:0] mio, mlast, mcnt;
    logic [15:0] mlfsr;
    logic        oor, io;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 32'h1122_3344, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'h5, 32'h1122_3344, 1'b0, 4'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_000A, 4'hF, 32'h11BB_33DD, 1'b0, 4'hA};
    tbl[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'h0000_000A, 1'b0, 4'hA};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 4'hA};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b1, 4'hA};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 1'b1, 4'hA};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 4'hA};
    tbl[12] = '{1'b1, 1'b1, 32'h0000_0008, 32'h5566_7788, 4'hF, 32'h11BB_33DD, 1'b0, 4'hA};
    tbl[13] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 32'h5566_7788, 1'b0, 4'hA};
    tbl[14] = '{1'b0, 1'b1, 32'h8000_1234, 32'hFFFF_FF05, 4'h1, 32'h5566_7788, 1'b0, 4'h5};
    tbl[15] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'h0000_0005, 1'b0, 4'h5};
    tbl[16] = '{1'b1, 1'b0, 32'h0000_000B, 32'h0000_0000, 4'h0, 32'h5566_7788, 1'b0, 4'h5};

    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;

    chk("reset_ready", 32'(i0.MEM_READY), 32'd1);
    chk("reset_valid", 32'(i0.MEM_VALID), 32'd0);
    chk("reset_data", i0.MEM_DATA, 32'h0);
    chk("reset_err", 32'(i0.MEM_ERR), 32'd0);
    chk("reset_leds", 32'(leds0), 32'd0);
    chk("reset_cnt", cnt0, 32'd0);
    chk("reset_ready1", 32'(i1.MEM_READY), 32'd1);

    // PAB_VALID without RD/WR must be ignored
    drive(0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    chk("noop_ready", 32'(i0.MEM_READY), 32'd1);
    chk("noop_valid", 32'(i0.MEM_VALID), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    for (int i = 0; i < 17; i++) begin
      txn(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, rdata, err, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("tbl%0d_data", i), rdata, tbl[i].exp_data);
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_cnt", i), cnt0, 32'(i + 1));
      chk($sformatf("tbl%0d_leds", i), 32'(leds0), 32'(tbl[i].exp_leds));
    end

    // PAB_VALID held high through DRAIN: no re-accept until it drops
    drive(0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
    k = 0;
    @(posedge clk); #1;
    while (!i0.MEM_VALID && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("hold_valid_seen", 32'(i0.MEM_VALID), 32'd1);
    chk("hold_data", i0.MEM_DATA, 32'h5566_7788);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_ready%0d", c), 32'(i0.MEM_READY), 32'd0);
      chk($sformatf("hold_novalid%0d", c), 32'(i0.MEM_VALID), 32'd0);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("hold_ready_back", 32'(i0.MEM_READY), 32'd1);
    chk("hold_cnt", cnt0, 32'd18);

    // Reset while a write to word 1 is in BUSY
    drive(0, 1'b1, 1'b0, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    chk("rst_ready", 32'(i0.MEM_READY), 32'd1);
    chk("rst_cnt", cnt0, 32'd0);
    chk("rst_leds", 32'(leds0), 32'd0);
    chk("rst_data", i0.MEM_DATA, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (i0.MEM_VALID) seen = 1'b1;
    end
    chk("rst_no_valid", 32'(seen), 32'd0);
    txn(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rdata, err, lat);
    chk("rst_ram1", rdata, 32'h0);
    chk("rst_lat", 32'(lat), 32'd3);
    chk("rst_cnt1", cnt0, 32'd1);
    txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rdata, err, lat);
    chk("rst_ram2_kept", rdata, 32'h5566_7788);

    // Jittered instance against the reference model
    mlfsr = 16'hACE1;
    mio   = 32'h0;
    mlast = 32'h0;
    mcnt  = 32'h0;
    for (int i = 0; i < 56; i++) begin
      if (i < 16) begin
        rd = 1'b0; wr = 1'b1; a = 32'(i * 4); d = $urandom; be = 4'hF;
      end else begin
        op = $urandom_range(1, 3);
        rd = (op & 1) != 0;
        wr = (op & 2) != 0;
        k  = $urandom_range(0, 5);
        if (k <= 3)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        else if (k == 4) a = 32'h8000_0000 | $urandom;
        else             a = ($urandom & 32'h7FFF_FFFF) | 32'h40;
        d  = $urandom;
        be = 4'($urandom);
      end
      exp_lat = 2 + int'(mlfsr & 16'h3);
      mlfsr   = lfsr_next(mlfsr);
      io  = a[31];
      oor = !a[31] && ((a >> 6) != 0);
      idx = int'((a >> 2) & 32'hF);
      if (rd) mlast = oor ? 32'hDEAD_BEEF : (io ? mio : mram[idx]);
      if (wr && !oor) begin
        if (io) mio = bmerge(mio, d, be);
        else    mram[idx] = bmerge(mram[idx], d, be);
      end
      mcnt = mcnt + 32'd1;
      txn(1, rd, wr, a, d, be, rdata, err, lat);
      chk($sformatf("jit%0d_lat", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("jit%0d_range", i), 32'(lat >= 2 && lat <= 5), 32'd1);
      chk($sformatf("jit%0d_data", i), rdata, mlast);
      chk($sformatf("jit%0d_err", i), 32'(err), 32'(oor));
      chk($sformatf("jit%0d_cnt", i), cnt1, mcnt);
      chk($sformatf("jit%0d_leds", i), 32'(leds1), 32'(mio[3:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
